mux8_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 8-way 16-bit mux datapath between 8 requesters.

---
 rtl/mux8_rr_arbiter_pkg.sv | 19 +
 rtl/mux8_rr_arbiter_if.sv | 25 ++
 rtl/mux8_rr_arbiter_rr_pick8.sv | 23 ++
 rtl/mux8_rr_arbiter.sv | 102 ++++++++++
 tb/tb_mux8_rr_arbiter.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants and types for the 8-requester round-robin mux arbiter.
// Optional burst limit is enabled by defining MUX8_ARB_TIMEOUT_EN.
package mux8_arb_pkg;
    localparam int N_REQ             = 8;
    localparam int SEL_W             = 3;
    localparam int DEFAULT_MAX_BURST = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Beat counter width: wide enough to hold max_burst, never narrower than 5 bits.
    function automatic int cnt_width(input int max_burst);
        int w;
        w = $clog2(max_burst + 1);
        return (w < 5) ? 5 : w;
    endfunction
endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Handshake bundle between the 8 requesters, the arbiter and the downstream consumer.
interface mux8_rr_arbiter_if;
    import mux8_arb_pkg::*;

    // Valid/ready: a beat moves on a rising edge where out_valid_o and out_ready_i are both 1;
    // valid may drop while the grant is held, and ready_o[k] mirrors out_ready_i to the granted requester.
    logic [N_REQ-1:0] req_i;
    logic [N_REQ-1:0] last_i;
    logic             out_ready_i;
    logic [SEL_W-1:0] sel_o;
    logic [N_REQ-1:0] grant_o;
    logic [N_REQ-1:0] ready_o;
    logic             out_valid_o;
    logic             out_last_o;

    modport master (
        input  req_i, last_i, out_ready_i,
        output sel_o, grant_o, ready_o, out_valid_o, out_last_o
    );

    modport slave (
        output req_i, last_i, out_ready_i,
        input  sel_o, grant_o, ready_o, out_valid_o, out_last_o
    );
endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Rotating priority encoder: first set request bit scanning from ptr upward, wrapping 7->0.
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);
    always_comb begin
        logic [SEL_W-1:0] cand;
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + SEL_W'(i);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin burst arbiter driving the select of an external 8:1 16-bit mux.
// Define MUX8_ARB_TIMEOUT_EN to cap each grant at MAX_BURST transferred beats.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mux8_rr_arbiter_if.master bus,
    output logic [0:0]       dbg_state,
    output logic [SEL_W-1:0] dbg_ptr
);
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_BUSY = BUSY;

    logic [0:0]       state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] sel_q;
    logic [N_REQ-1:0] grant_q;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             busy;
    logic             valid;
    logic             xfer;
    logic             hit_limit;
    logic             end_burst;

    rr_pick8 u_pick (
        .req (bus.req_i),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign busy      = (state == ST_BUSY);
    assign valid     = busy & bus.req_i[sel_q];
    assign xfer      = valid & bus.out_ready_i;
    assign end_burst = xfer & (bus.last_i[sel_q] | hit_limit);

`ifdef MUX8_ARB_TIMEOUT_EN
    localparam int CNT_W = cnt_width(MAX_BURST);
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating increment; the limit compare uses the post-transfer count.
    assign cnt_inc   = (&beat_cnt) ? beat_cnt : beat_cnt + 1'b1;
    assign hit_limit = (cnt_inc == CNT_W'(MAX_BURST));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_cnt <= '0;
        end else if (state == ST_IDLE && pick_any) begin
            beat_cnt <= '0;
        end else if (xfer) begin
            beat_cnt <= cnt_inc;
        end
    end
`else
    assign hit_limit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            sel_q   <= '0;
            grant_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state   <= ST_BUSY;
                        sel_q   <= pick_idx;
                        grant_q <= N_REQ'(1) << pick_idx;
                    end
                end
                ST_BUSY: begin
                    // sel_q is kept after release so the idle mux select stays stable.
                    if (end_burst) begin
                        state   <= ST_IDLE;
                        grant_q <= '0;
                        ptr     <= sel_q + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.sel_o       = sel_q;
    assign bus.grant_o     = grant_q;
    assign bus.ready_o     = grant_q & {N_REQ{bus.out_ready_i}};
    assign bus.out_valid_o = valid;
    assign bus.out_last_o  = bus.last_i[sel_q] & valid;
    assign dbg_state       = state;
    assign dbg_ptr         = ptr;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter; the burst-limit scenario follows MUX8_ARB_TIMEOUT_EN.
module tb_mux8_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [0:0] dbg_state;
    logic [2:0] dbg_ptr;
    int         n_checks = 0;
    int         n_errors = 0;

    mux8_rr_arbiter_if bus ();

    mux8_rr_arbiter #(.MAX_BURST(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks run at that same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_i = '0;
        bus.last_i = '0;
        bus.out_ready_i = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_i = 8'hFF;
        bus.last_i = 8'h00;
        bus.out_ready_i = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.grant_o !== 8'h00) begin n_errors++; $display("FAIL reset_grant: got %h want 00", bus.grant_o); end
        n_checks++; if (bus.out_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid_o); end
        n_checks++; if (bus.sel_o !== 3'd0) begin n_errors++; $display("FAIL reset_sel: got %0d want 0", bus.sel_o); end
        n_checks++; if (bus.ready_o !== 8'h00) begin n_errors++; $display("FAIL reset_ready: got %h want 00", bus.ready_o); end
        n_checks++; if (dbg_ptr !== 3'd0) begin n_errors++; $display("FAIL reset_ptr: got %0d want 0", dbg_ptr); end
        rst = 1'b0;
        bus.req_i = '0;
    endtask

    task automatic test_single();
        int xfers;
        do_reset();
        bus.req_i = 8'h04;
        bus.out_ready_i = 1'b1;
        n_checks++; if (bus.grant_o !== 8'h00) begin n_errors++; $display("FAIL single_pre_grant: got %h want 00", bus.grant_o); end
        tick();
        n_checks++; if (bus.grant_o !== 8'h04) begin n_errors++; $display("FAIL single_grant: got %h want 04", bus.grant_o); end
        n_checks++; if (bus.sel_o !== 3'd2) begin n_errors++; $display("FAIL single_sel: got %0d want 2", bus.sel_o); end
        xfers = 0;
        for (int b = 1; b <= 3; b++) begin
            bus.last_i = (b == 3) ? 8'h04 : 8'h00;
            #1;
            if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) xfers++;
            n_checks++; if (bus.out_last_o !== (b == 3)) begin n_errors++; $display("FAIL single_last_beat%0d: got %b want %b", b, bus.out_last_o, (b == 3)); end
            tick();
        end
        bus.req_i = '0;
        bus.last_i = '0;
        n_checks++; if (xfers !== 3) begin n_errors++; $display("FAIL single_xfers: got %0d want 3", xfers); end
        n_checks++; if (bus.grant_o !== 8'h00) begin n_errors++; $display("FAIL single_release: got %h want 00", bus.grant_o); end
        n_checks++; if (dbg_ptr !== 3'd3) begin n_errors++; $display("FAIL single_ptr: got %0d want 3", dbg_ptr); end
        n_checks++; if (bus.sel_o !== 3'd2) begin n_errors++; $display("FAIL single_sel_hold: got %0d want 2", bus.sel_o); end
        n_checks++; if (dbg_state !== 1'b0) begin n_errors++; $display("FAIL single_state_idle: got %b want 0", dbg_state); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_seq [8];
        exp_seq = '{8'h01, 8'h00, 8'h80, 8'h00, 8'h01, 8'h00, 8'h80, 8'h00};
        do_reset();
        bus.req_i = 8'h81;
        bus.last_i = 8'hFF;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++; if (bus.grant_o !== exp_seq[i]) begin n_errors++; $display("FAIL rr_grant_step%0d: got %h want %h", i, bus.grant_o, exp_seq[i]); end
        end
        n_checks++; if (dbg_ptr !== 3'd0) begin n_errors++; $display("FAIL rr_ptr_wrap: got %0d want 0", dbg_ptr); end
        bus.req_i = '0;
        bus.last_i = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.req_i = 8'h20;
        bus.out_ready_i = 1'b0;
        tick();
        n_checks++; if (bus.sel_o !== 3'd5) begin n_errors++; $display("FAIL bp_sel: got %0d want 5", bus.sel_o); end
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (bus.ready_o !== 8'h00) begin n_errors++; $display("FAIL bp_ready_c%0d: got %h want 00", c, bus.ready_o); end
            n_checks++; if (bus.out_valid_o !== 1'b1) begin n_errors++; $display("FAIL bp_valid_c%0d: got %b want 1", c, bus.out_valid_o); end
            n_checks++; if (bus.grant_o !== 8'h20) begin n_errors++; $display("FAIL bp_grant_c%0d: got %h want 20", c, bus.grant_o); end
            tick();
        end
        bus.out_ready_i = 1'b1;
        bus.req_i = 8'h00;
        bus.last_i = 8'h20;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (bus.out_valid_o !== 1'b0) begin n_errors++; $display("FAIL drop_valid_c%0d: got %b want 0", c, bus.out_valid_o); end
            n_checks++; if (bus.grant_o !== 8'h20) begin n_errors++; $display("FAIL drop_grant_c%0d: got %h want 20", c, bus.grant_o); end
            n_checks++; if (bus.ready_o !== 8'h20) begin n_errors++; $display("FAIL drop_ready_c%0d: got %h want 20", c, bus.ready_o); end
            tick();
        end
        bus.req_i = 8'h20;
        #1;
        n_checks++; if (bus.out_last_o !== 1'b1) begin n_errors++; $display("FAIL bp_out_last: got %b want 1", bus.out_last_o); end
        tick();
        n_checks++; if (bus.grant_o !== 8'h00) begin n_errors++; $display("FAIL bp_release: got %h want 00", bus.grant_o); end
        n_checks++; if (dbg_ptr !== 3'd6) begin n_errors++; $display("FAIL bp_ptr: got %0d want 6", dbg_ptr); end
        bus.req_i = '0;
        bus.last_i = '0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.req_i = 8'h08;
        bus.out_ready_i = 1'b1;
        tick();
        n_checks++; if (bus.grant_o !== 8'h08) begin n_errors++; $display("FAIL midrst_grant: got %h want 08", bus.grant_o); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (bus.grant_o !== 8'h00) begin n_errors++; $display("FAIL midrst_abort: got %h want 00", bus.grant_o); end
        n_checks++; if (dbg_ptr !== 3'd0) begin n_errors++; $display("FAIL midrst_ptr: got %0d want 0", dbg_ptr); end
        bus.req_i = 8'h09;
        tick();
        n_checks++; if (bus.grant_o !== 8'h01) begin n_errors++; $display("FAIL midrst_regrant: got %h want 01", bus.grant_o); end
        n_checks++; if (bus.sel_o !== 3'd0) begin n_errors++; $display("FAIL midrst_sel: got %0d want 0", bus.sel_o); end
        bus.req_i = '0;
    endtask

    task automatic test_burst_limit();
        do_reset();
        bus.req_i = 8'h42;
        bus.last_i = 8'h00;
        bus.out_ready_i = 1'b1;
        tick();
        n_checks++; if (bus.grant_o !== 8'h02) begin n_errors++; $display("FAIL limit_grant1: got %h want 02", bus.grant_o); end
        for (int b = 0; b < 3; b++) tick();
        n_checks++; if (bus.grant_o !== 8'h02) begin n_errors++; $display("FAIL limit_hold_b3: got %h want 02", bus.grant_o); end
        tick();
`ifdef MUX8_ARB_TIMEOUT_EN
        n_checks++; if (bus.grant_o !== 8'h00) begin n_errors++; $display("FAIL limit_release: got %h want 00", bus.grant_o); end
        n_checks++; if (dbg_ptr !== 3'd2) begin n_errors++; $display("FAIL limit_ptr: got %0d want 2", dbg_ptr); end
        tick();
        n_checks++; if (bus.grant_o !== 8'h40) begin n_errors++; $display("FAIL limit_next_grant: got %h want 40", bus.grant_o); end
`else
        for (int b = 0; b < 8; b++) tick();
        n_checks++; if (bus.grant_o !== 8'h02) begin n_errors++; $display("FAIL nolimit_hold: got %h want 02", bus.grant_o); end
        n_checks++; if (bus.sel_o !== 3'd1) begin n_errors++; $display("FAIL nolimit_sel: got %0d want 1", bus.sel_o); end
`endif
        bus.req_i = '0;
    endtask

    initial begin
        bus.req_i = '0;
        bus.last_i = '0;
        bus.out_ready_i = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid_burst();
        test_burst_limit();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
